// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter: byte requests in, ack/grant back,
// plus the start/ready handshake toward the UART transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 tx_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;

  modport master (
    input  req, req_data, tx_ready,
    output ack, grant, busy, tx_start, tx_data
  );

  modport slave (
    output req, req_data, tx_ready,
    input  ack, grant, busy, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte scheduler for one UART transmitter; grant 1 clk after req, tx_start 2 clk after req.
// Stalls in IDLE while the synchronized tx_ready is low; holds tx_start/tx_data until the frame is accepted.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, START, DONE} state_t;

  state_t             state, state_nxt;
  logic               sync_q1, tx_ready_s;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]      gidx, gidx_nxt;
  logic [IW-1:0]      sel_idx;
  logic               sel_found;
  logic [IW:0]        cand;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [7:0]         burst_cnt, burst_cnt_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [NUM_REQ-1:0] ack_q, ack_nxt;
  logic               tx_start_q, tx_start_nxt;
  logic [7:0]         tx_data_q, tx_data_nxt;
  logic [7:0]         req_byte [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_byte[i] = bus.req_data[8*i +: 8];
  end

  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state != IDLE);

  // tx_ready lives in the UART clock domain; reset to "idle" so an unknown line never blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1    <= 1'b1;
      tx_ready_s <= 1'b1;
    end else begin
      sync_q1    <= bus.tx_ready;
      tx_ready_s <= sync_q1;
    end
  end

  // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    cand       = '0;
    sel_onehot = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (bus.req[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
    sel_onehot[sel_idx] = 1'b1;
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    gidx_nxt      = gidx;
    burst_cnt_nxt = burst_cnt;
    grant_nxt     = grant_q;
    ack_nxt       = '0;
    tx_start_nxt  = 1'b0;
    tx_data_nxt   = tx_data_q;
    case (state)
      IDLE: begin
        if (sel_found && tx_ready_s) begin
          state_nxt     = LOAD;
          gidx_nxt      = sel_idx;
          grant_nxt     = sel_onehot;
          ack_nxt       = sel_onehot;
          burst_cnt_nxt = '0;
        end
      end
      LOAD: begin
        state_nxt    = START;
        tx_data_nxt  = req_byte[gidx];
        tx_start_nxt = 1'b1;
        if (burst_cnt != 8'hFF) begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end
      START: begin
        if (!tx_ready_s) begin
          state_nxt = DONE;
        end else begin
          tx_start_nxt = 1'b1;
        end
      end
      DONE: begin
        if (tx_ready_s) begin
          if (bus.req[gidx] && (burst_cnt < 8'(MAX_BURST))) begin
            state_nxt = LOAD;
            ack_nxt   = grant_q;
          end else begin
            state_nxt  = IDLE;
            rr_ptr_nxt = gidx;
            grant_nxt  = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= IW'(NUM_REQ - 1);
      gidx       <= '0;
      burst_cnt  <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      gidx       <= gidx_nxt;
      burst_cnt  <= burst_cnt_nxt;
      grant_q    <= grant_nxt;
      ack_q      <= ack_nxt;
      tx_start_q <= tx_start_nxt;
      tx_data_q  <= tx_data_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requester queues, a transmitter model and a
// transaction-level round-robin/burst model predicting the frame sequence.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int MB = 3;

  logic clk;
  logic rst;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #52 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester side: per-requester byte queues held in flat arrays.
  logic [7:0]        mem [NR][1024];
  int                head [NR];
  int                tail [NR];
  int                rstart [NR];
  bit                pend [NR];
  int                ack_cnt [NR];
  logic [NR-1:0]     rq;
  logic [8*NR-1:0]   rd;

  // Frames seen by the transmitter model.
  int                log_r [64];
  logic [7:0]        log_d [64];
  int                nlog;

  int                last_owner;
  int                fix_acc, fix_frame;
  bit                tx_force_low;
  int                tx_phase, tx_cnt, tx_d;
  bit                tx_fell;
  logic [7:0]        tx_held;

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic bit queues_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) if (head[i] != tail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic push(input int i, input logic [7:0] d);
    mem[i][tail[i]] = d;
    tail[i]++;
  endtask

  task automatic begin_round();
    for (int i = 0; i < NR; i++) begin
      rstart[i]  = tail[i];
      ack_cnt[i] = 0;
    end
    nlog = 0;
  endtask

  // Requesters: present head byte; pop one cycle after the ack so the byte stays stable
  // across the edge that latches it.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (rst !== 1'b1) begin
          pend[i] = 1'b0;
        end else begin
          if (pend[i] && head[i] < tail[i]) head[i]++;
          pend[i] = bus.ack[i];
        end
        rq[i] = (head[i] < tail[i]);
        rd[8*i +: 8] = rq[i] ? mem[i][head[i]] : 8'h00;
      end
      bus.req      = rq;
      bus.req_data = rd;
    end
  end

  // Transmitter model: accept delay, then tx_ready low for the frame duration.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst !== 1'b1) begin
        bus.tx_ready = 1'b1;
        tx_phase     = 0;
      end else begin
        case (tx_phase)
          0: begin
            bus.tx_ready = !tx_force_low;
            if (bus.tx_start && !tx_force_low) begin
              tx_cnt   = (fix_acc > 0) ? fix_acc : int'($urandom_range(1, 6));
              tx_held  = bus.tx_data;
              tx_phase = 1;
            end
          end
          1: begin
            check_eq("tx_start_held", bus.tx_start, 1);
            check_eq("tx_data_stable", bus.tx_data, tx_held);
            tx_cnt--;
            if (tx_cnt == 0) begin
              if (nlog < 64) begin
                log_r[nlog] = onehot_idx(bus.grant);
                log_d[nlog] = bus.tx_data;
              end
              nlog++;
              bus.tx_ready = 1'b0;
              tx_cnt   = (fix_frame > 0) ? fix_frame : int'($urandom_range(6, 20));
              tx_d     = 0;
              tx_fell  = 1'b0;
              tx_phase = 2;
            end
          end
          default: begin
            tx_d++;
            if (!tx_fell && !bus.tx_start) begin
              check_eq("tx_start_fall_delay", tx_d, 3);
              tx_fell = 1'b1;
            end
            tx_cnt--;
            if (tx_cnt == 0) begin
              check_eq("tx_start_dropped", tx_fell, 1);
              bus.tx_ready = 1'b1;
              tx_phase     = 0;
            end
          end
        endcase
      end
    end
  end

  // Cycle-level invariants and ack counting.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        check_eq("busy_vs_grant", bus.busy, (bus.grant != '0));
        check_eq("grant_onehot", ($countones(bus.grant) <= 1), 1);
        if (bus.ack != '0) check_eq("ack_matches_grant", bus.ack, bus.grant);
        for (int i = 0; i < NR; i++) if (bus.ack[i]) ack_cnt[i]++;
      end
    end
  end

  // Reference: round-robin over requesters with pending bytes, up to MB bytes per turn.
  task automatic finish_round();
    int         rem [NR];
    int         rdp [NR];
    int         er [$];
    logic [7:0] ed [$];
    int         c, found, take, cyc;
    for (int i = 0; i < NR; i++) begin
      rem[i] = tail[i] - rstart[i];
      rdp[i] = rstart[i];
    end
    while (1) begin
      found = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (last_owner + k) % NR;
        if (found < 0 && rem[c] > 0) found = c;
      end
      if (found < 0) break;
      take = (rem[found] < MB) ? rem[found] : MB;
      for (int t = 0; t < take; t++) begin
        er.push_back(found);
        ed.push_back(mem[found][rdp[found]]);
        rdp[found]++;
      end
      rem[found] -= take;
      last_owner = found;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(queues_empty() && bus.busy == 1'b0 && tx_phase == 0) && cyc < 4000);
    check_eq("round_drained", (cyc < 4000), 1);
    check_eq("frame_count", nlog, er.size());
    for (int j = 0; j < er.size() && j < nlog && j < 64; j++) begin
      check_eq("frame_owner", log_r[j], er[j]);
      check_eq("frame_byte", log_d[j], ed[j]);
    end
    for (int i = 0; i < NR; i++) check_eq("ack_count", ack_cnt[i], tail[i] - rstart[i]);
  endtask

  task automatic run_counts(input int n0, input int n1, input int n2, input int n3);
    int n [NR];
    n = '{n0, n1, n2, n3};
    begin_round();
    for (int i = 0; i < NR; i++)
      for (int b = 0; b < n[i]; b++) push(i, 8'($urandom));
    finish_round();
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0; tail[i] = 0; rstart[i] = 0; pend[i] = 1'b0; ack_cnt[i] = 0;
    end
    nlog = 0; last_owner = NR - 1;
    fix_acc = 0; fix_frame = 0; tx_force_low = 1'b0;
    tx_phase = 0; tx_cnt = 0; tx_d = 0; tx_fell = 1'b0; tx_held = 8'h00;
    rst = 1'b0;
    bus.req = '0; bus.req_data = '0; bus.tx_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("reset_grant", bus.grant, 0);
    check_eq("reset_ack", bus.ack, 0);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_tx_start", bus.tx_start, 0);
    check_eq("reset_tx_data", bus.tx_data, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // Single requester with exact latency.
    fix_acc = 5; fix_frame = 100;
    begin_round();
    push(2, 8'hA5);
    @(negedge clk);
    check_eq("lat_grant", bus.grant, 4'b0100);
    check_eq("lat_ack", bus.ack, 4'b0100);
    check_eq("lat_no_start_yet", bus.tx_start, 0);
    @(negedge clk);
    check_eq("lat_tx_start", bus.tx_start, 1);
    check_eq("lat_tx_data", bus.tx_data, 8'hA5);
    check_eq("lat_ack_pulse", bus.ack, 0);
    finish_round();
    fix_acc = 0; fix_frame = 0;

    // rr_ptr now 2: requester 3 must precede requester 0.
    run_counts(1, 0, 0, 1);
    run_counts(4, 4, 4, 4);
    run_counts(0, 10, 0, 10);
    run_counts(2, 0, 0, 0);

    // Handshake stall: transmitter busy at request time.
    begin_round();
    tx_force_low = 1'b1;
    repeat (4) @(negedge clk);
    push(1, 8'h3C);
    repeat (10) @(negedge clk);
    check_eq("stall_grant_none", bus.grant, 0);
    check_eq("stall_tx_start_none", bus.tx_start, 0);
    check_eq("stall_busy_none", bus.busy, 0);
    fix_acc = 50;
    tx_force_low = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check_eq("stall_no_early_grant", bus.grant, 0);
    end
    @(negedge clk);
    check_eq("stall_grant", bus.grant, 4'b0010);
    finish_round();
    fix_acc = 0;

    // Reset while waiting for the frame to finish.
    begin_round();
    for (int b = 0; b < 5; b++) push(1, 8'($urandom_range(1, 255)));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(tx_phase == 2 && bus.tx_start == 1'b0 && bus.busy == 1'b1) && cyc < 2000);
    check_eq("reached_done", (cyc < 2000), 1);
    rst = 1'b0;
    #1;
    check_eq("midrst_grant", bus.grant, 0);
    check_eq("midrst_ack", bus.ack, 0);
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_tx_start", bus.tx_start, 0);
    check_eq("midrst_tx_data", bus.tx_data, 8'h00);
    for (int i = 0; i < NR; i++) head[i] = tail[i];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    last_owner = NR - 1;
    begin_round();
    push(3, 8'($urandom));
    push(2, 8'($urandom));
    push(0, 8'($urandom));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.grant == '0 && cyc < 100);
    check_eq("post_reset_first_grant", bus.grant, 4'b0001);
    finish_round();

    // Random traffic.
    for (int r = 0; r < 15; r++)
      run_counts($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
